bbox_overlay: RTL and testbench

- Draws the tracker's bounding box onto the RGB video stream.
- Takes the tracker result (valid pulse plus center/width/height) and the same 24-bit raster pixel stream, and recolours every pixel on the box border.
- Passes all other pixels through unchanged into an output FIFO for the display/VGA path.
- Sits downstream of the tracking block, in parallel with it on the pixel path.

---
 rtl/bbox_pkg.sv | 15 +
 rtl/bbox_bounds.sv | 21 ++
 rtl/fifo.sv | 39 +++
 rtl/bbox_overlay.sv | 119 +++++++++++
 tb/tb_bbox_overlay.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/bbox_pkg.sv
// bbox_pkg: shared types and the border test for the bounding-box overlay
package bbox_pkg;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;
  typedef logic [11:0] coord_t;
  typedef struct packed {
    coord_t x0;
    coord_t x1;
    coord_t y0;
    coord_t y1;
  } box_t;
  function automatic logic on_border(input coord_t x, input coord_t y, input box_t b, input coord_t t);
    return x >= b.x0 && x <= b.x1 && y >= b.y0 && y <= b.y1 &&
           (x - b.x0 < t || b.x1 - x < t || y - b.y0 < t || b.y1 - y < t);
  endfunction
endpackage

// File: rtl/bbox_bounds.sv
// bbox_bounds: converts a box center/size into clamped low/high bounds on one axis
module bbox_bounds
  import bbox_pkg::*;
#(
  parameter coord_t LIMIT = 12'd639
) (
  input  coord_t center_i,
  input  coord_t size_i,
  output coord_t lo_o,
  output coord_t hi_o
);
  logic [12:0] hx, hi;
  coord_t      lo;
  always_comb begin
    hx   = ({1'b0, size_i} - 13'd1) >> 1;
    lo   = {1'b0, center_i} < hx ? '0 : center_i - hx[11:0];
    hi   = {1'b0, lo} + {1'b0, size_i} - 13'd1;
    lo_o = lo;
    hi_o = hi > {1'b0, LIMIT} ? LIMIT : hi[11:0];
  end
endmodule

// File: rtl/fifo.sv
// fifo: synchronous FIFO with registered read data; writes when full and reads when empty are ignored
module fifo #(
  parameter int DW    = 24,
  parameter int DEPTH = 1024
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] din_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wp_q, rp_q;
  logic [DW-1:0] dout_q;
  logic          do_wr, do_rd;
  assign empty_o = wp_q == rp_q;
  assign full_o  = wp_q[AW] != rp_q[AW] && wp_q[AW-1:0] == rp_q[AW-1:0];
  assign do_wr   = wr_en_i && !full_o;
  assign do_rd   = rd_en_i && !empty_o;
  assign dout_o  = dout_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wp_q   <= '0;
      rp_q   <= '0;
      dout_q <= '0;
    end else begin
      if (do_wr) wp_q <= wp_q + 1'b1;
      if (do_rd) begin
        rp_q   <= rp_q + 1'b1;
        dout_q <= mem[rp_q[AW-1:0]];
      end
    end
  always_ff @(posedge clk_i)
    if (do_wr) mem[wp_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/bbox_overlay.sv
// bbox_overlay: recolours the border of the tracked box on a raster RGB stream between two FIFOs
module bbox_overlay
  import bbox_pkg::*;
#(
  parameter int          WIDTH       = 640,
  parameter int          HEIGHT      = 480,
  parameter int          THICKNESS   = 2,
  parameter logic [23:0] BOX_COLOR   = 24'hFF0000,
  parameter int          HOLD_FRAMES = 2,
  parameter int          FIFO_DEPTH  = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        box_valid,
  input  logic [11:0] center_x,
  input  logic [11:0] center_y,
  input  logic [11:0] width,
  input  logic [11:0] height,
  input  logic        in_wr_en,
  input  logic [7:0]  iR,
  input  logic [7:0]  iG,
  input  logic [7:0]  iB,
  output logic        in_full,
  input  logic        out_rd_en,
  output logic [7:0]  oR,
  output logic [7:0]  oG,
  output logic [7:0]  oB,
  output logic        out_empty,
  output logic        overlay_active
);
  localparam coord_t     XMAX = coord_t'(WIDTH - 1);
  localparam coord_t     YMAX = coord_t'(HEIGHT - 1);
  localparam coord_t     THK  = coord_t'(THICKNESS);
  localparam logic [7:0] HOLD = 8'(HOLD_FRAMES);
  state_t      state_q, state_d;
  coord_t      x_q, x_d, y_q, y_d;
  box_t        pend_box_q, pend_box_d, act_box_q, act_box_d, new_box;
  logic        pend_q, pend_d, active_q, active_d;
  logic [7:0]  hold_q, hold_d;
  logic        in_rd, in_empty, out_wr, out_full, go, frame_start;
  logic [23:0] in_dout, out_din, out_dout;
  coord_t      nx0, nx1, ny0, ny1;
  bbox_bounds #(.LIMIT(XMAX)) u_bx (.center_i(center_x), .size_i(width), .lo_o(nx0), .hi_o(nx1));
  bbox_bounds #(.LIMIT(YMAX)) u_by (.center_i(center_y), .size_i(height), .lo_o(ny0), .hi_o(ny1));
  fifo #(.DW(24), .DEPTH(FIFO_DEPTH)) u_in (
    .clk_i(clock), .rst_i(reset), .wr_en_i(in_wr_en), .din_i({iR, iG, iB}),
    .rd_en_i(in_rd), .dout_o(in_dout), .full_o(in_full), .empty_o(in_empty)
  );
  fifo #(.DW(24), .DEPTH(FIFO_DEPTH)) u_out (
    .clk_i(clock), .rst_i(reset), .wr_en_i(out_wr), .din_i(out_din),
    .rd_en_i(out_rd_en), .dout_o(out_dout), .full_o(out_full), .empty_o(out_empty)
  );
  assign new_box        = '{x0: nx0, x1: nx1, y0: ny0, y1: ny1};
  assign go             = state_q == S_IDLE && !in_empty && !out_full;
  assign frame_start    = go && x_q == '0 && y_q == '0;
  assign out_din        = active_q && on_border(x_q, y_q, act_box_q, THK) ? BOX_COLOR : in_dout;
  assign {oR, oG, oB}   = out_dout;
  assign overlay_active = active_q;
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    pend_d     = pend_q;
    pend_box_d = pend_box_q;
    act_box_d  = act_box_q;
    active_d   = active_q;
    hold_d     = hold_q;
    in_rd      = 1'b0;
    out_wr     = 1'b0;
    if (box_valid) begin
      pend_d     = 1'b1;
      pend_box_d = new_box;
    end
    // a box arriving on the frame-start cycle goes straight to the active set
    if (frame_start) begin
      if (box_valid || pend_q) begin
        act_box_d = box_valid ? new_box : pend_box_q;
        pend_d    = 1'b0;
        active_d  = 1'b1;
        hold_d    = HOLD;
      end else if (hold_q != '0) hold_d = hold_q - 1'b1;
      else active_d = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        in_rd   = go;
        state_d = go ? S_READ : S_IDLE;
      end
      S_READ: state_d = S_WRITE;
      S_WRITE: begin
        out_wr  = 1'b1;
        x_d     = x_q == XMAX ? '0 : x_q + 1'b1;
        y_d     = x_q != XMAX ? y_q : y_q == YMAX ? '0 : y_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      pend_q     <= 1'b0;
      pend_box_q <= '0;
      act_box_q  <= '0;
      active_q   <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pend_q     <= pend_d;
      pend_box_q <= pend_box_d;
      act_box_q  <= act_box_d;
      active_q   <= active_d;
      hold_q     <= hold_d;
    end
endmodule

// File: tb/tb_bbox_overlay.sv
// tb_bbox_overlay: directed frame-level checks of the box overlay on an 8x6 raster
module tb_bbox_overlay;
  localparam int W = 8;
  localparam int H = 6;
  typedef struct {
    int cx, cy, w, h;
    int x0, x1, y0, y1;
  } vec_t;
  logic        clock = 1'b0, reset = 1'b1, box_valid = 1'b0;
  logic [11:0] center_x = '0, center_y = '0, width = 12'd1, height = 12'd1;
  logic        in_wr_en = 1'b0, out_rd_en = 1'b0;
  logic [7:0]  iR = '0, iG = '0, iB = '0, oR, oG, oB;
  logic        in_full, out_empty, overlay_active;
  int          checks = 0, errors = 0, seed = 0;
  vec_t        tbl [5];
  always #5 clock = ~clock;
  bbox_overlay #(
    .WIDTH(W), .HEIGHT(H), .THICKNESS(1), .BOX_COLOR(24'hFF0000),
    .HOLD_FRAMES(2), .FIFO_DEPTH(8)
  ) dut (
    .clock(clock), .reset(reset), .box_valid(box_valid),
    .center_x(center_x), .center_y(center_y), .width(width), .height(height),
    .in_wr_en(in_wr_en), .iR(iR), .iG(iG), .iB(iB), .in_full(in_full),
    .out_rd_en(out_rd_en), .oR(oR), .oG(oG), .oB(oB),
    .out_empty(out_empty), .overlay_active(overlay_active)
  );
  function automatic logic [23:0] ramp(input int p);
    return {8'(p * 5 + seed), 8'(p), ~8'(p)};
  endfunction
  function automatic logic [23:0] exp_px(input int x, input int y, input logic [23:0] d,
                                         input bit draw, input int x0, input int x1,
                                         input int y0, input int y1);
    if (draw && x >= x0 && x <= x1 && y >= y0 && y <= y1 &&
        (x == x0 || x == x1 || y == y0 || y == y1)) return 24'hFF0000;
    return d;
  endfunction
  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic set_box(input int cx, input int cy, input int w, input int h);
    center_x = 12'(cx);
    center_y = 12'(cy);
    width    = 12'(w);
    height   = 12'(h);
  endtask
  task automatic pulse_box(input int cx, input int cy, input int w, input int h);
    @(negedge clock);
    set_box(cx, cy, w, h);
    box_valid = 1'b1;
    @(negedge clock);
    box_valid = 1'b0;
  endtask
  task automatic write_px(input logic [23:0] d, input bit pulse);
    @(negedge clock);
    {iR, iG, iB} = d;
    in_wr_en     = 1'b1;
    box_valid    = pulse;
    @(negedge clock);
    in_wr_en  = 1'b0;
    box_valid = 1'b0;
  endtask
  task automatic read_px(output logic [23:0] d, output bit ok);
    int n = 0;
    d = 'x;
    while (out_empty && n < 30) begin
      @(negedge clock);
      n++;
    end
    ok = !out_empty;
    if (ok) begin
      out_rd_en = 1'b1;
      @(negedge clock);
      out_rd_en = 1'b0;
      d = {oR, oG, oB};
    end
  endtask
  task automatic read_check(input string name, input logic [23:0] exp);
    logic [23:0] got;
    bit ok;
    read_px(got, ok);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: got no output pixel, expected %h", name, exp);
    end else check(name, got, exp);
  endtask
  task automatic run_frame(input string tag, input bit draw, input int x0, input int x1,
                           input int y0, input int y1, input int pulse_at, input bit exp_act);
    seed++;
    for (int p = 0; p < W * H; p++) begin
      write_px(ramp(p), p == pulse_at);
      read_check($sformatf("%s px(%0d,%0d)", tag, p % W, p / W),
                 exp_px(p % W, p / W, ramp(p), draw, x0, x1, y0, y1));
    end
    check({tag, " overlay_active"}, {23'b0, overlay_active}, {23'b0, exp_act});
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    logic [23:0] junk;
    bit ok;
    tbl[0] = '{3, 2, 4, 3, 2, 5, 1, 3};
    tbl[1] = '{0, 0, 5, 5, 0, 4, 0, 4};
    tbl[2] = '{7, 2, 6, 1, 5, 7, 2, 2};
    tbl[3] = '{4, 3, 1, 1, 4, 4, 3, 3};
    tbl[4] = '{1, 1, 3, 3, 0, 2, 0, 2};
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset in_full", {23'b0, in_full}, 24'd0);
    check("reset out_empty", {23'b0, out_empty}, 24'd1);
    check("reset overlay_active", {23'b0, overlay_active}, 24'd0);
    run_frame("nobox", 0, 0, 0, 0, 0, -1, 0);
    for (int i = 0; i < 5; i++) begin
      pulse_box(tbl[i].cx, tbl[i].cy, tbl[i].w, tbl[i].h);
      run_frame($sformatf("box%0d", i), 1, tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1, -1, 1);
    end
    run_frame("hold1", 1, 0, 2, 0, 2, -1, 1);
    run_frame("hold2", 1, 0, 2, 0, 2, -1, 1);
    run_frame("hold_off", 0, 0, 0, 0, 0, -1, 0);
    set_box(3, 2, 4, 3);
    run_frame("mid", 0, 0, 0, 0, 0, 20, 0);
    run_frame("mid_next", 1, 2, 5, 1, 3, -1, 1);
    seed++;
    for (int p = 0; p < 10; p++) write_px(ramp(p), 1'b0);
    for (int p = 0; p < 5; p++) read_px(junk, ok);
    reset = 1'b1;
    @(negedge clock);
    check("midreset out_empty", {23'b0, out_empty}, 24'd1);
    check("midreset overlay_active", {23'b0, overlay_active}, 24'd0);
    check("midreset in_full", {23'b0, in_full}, 24'd0);
    reset = 1'b0;
    pulse_box(3, 2, 4, 3);
    run_frame("post_reset", 1, 2, 5, 1, 3, -1, 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    seed++;
    for (int p = 0; p < 16; p++) write_px(ramp(p), 1'b0);
    repeat (40) @(negedge clock);
    check("fill in_full", {23'b0, in_full}, 24'd1);
    check("fill out_empty", {23'b0, out_empty}, 24'd0);
    write_px(24'h123456, 1'b0);
    for (int p = 0; p < 16; p++) read_check($sformatf("fill px%0d", p), ramp(p));
    repeat (20) @(negedge clock);
    check("drop out_empty", {23'b0, out_empty}, 24'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
